inst_issue_arb: RTL and testbench

INST_ISSUE_ARB -- requirements
Module: inst_issue_arb

---
 rtl/inst_issue_arb_pkg.sv | 27 ++
 rtl/inst_issue_arb_rr_arb2.sv | 37 +++
 rtl/inst_issue_arb.sv | 111 +++++++++++
 tb/tb_inst_issue_arb.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_issue_arb_pkg.sv
// Shared types for the instruction issue arbiter: opcodes, the 8-bit
// instruction field layout and the issue/drain FSM states.
package inst_issue_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_AND = 2'b11
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [1:0] rd;
    } inst_t;

    localparam int INST_W = $bits(inst_t);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_e;

endpackage

// File: rtl/inst_issue_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus a 1-bit priority
// pointer that moves to the other side after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic ptr;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            // A grant to side 0 hands priority to side 1, and vice versa.
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/inst_issue_arb.sv
// Issues instructions from two requesters into a pipeline, one per cycle,
// with a drain mode that stops issue and flushes the EX/WB stages.
module inst_issue_arb
    import inst_issue_arb_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST     = 8'h00,
    parameter int                DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [INST_W-1:0] req0_inst,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [INST_W-1:0] req1_inst,
    output logic              req1_ready,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_src,
    output logic [7:0]        issue_cnt0,
    output logic [7:0]        issue_cnt1
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic [1:0]       grant;
    logic             arb_en;
    logic             xfer;
    inst_t            sel_inst;

    // Reset gates the grant so both readies are low while rst is held.
    assign arb_en = (state == ST_RUN) && rst;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = |grant;
    assign sel_inst   = grant[1] ? inst_t'(req1_inst) : inst_t'(req0_inst);

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        drain_done    = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (drain_req) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // drain_req is ignored here: a started drain always completes.
                if (drain_cnt <= CNT_W'(1)) begin
                    state_nxt     = ST_DRAINED;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt - CNT_W'(1);
                end
            end
            ST_DRAINED: begin
                drain_done = drain_req;
                if (!drain_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt     = ST_RUN;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            inst_out   <= NOP_INST;
            inst_src   <= 1'b0;
            issue_cnt0 <= 8'h00;
            issue_cnt1 <= 8'h00;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (xfer) begin
                inst_out <= sel_inst;
                inst_src <= grant[1];
            end else begin
                inst_out <= NOP_INST;
                inst_src <= 1'b0;
            end
            if (grant[0]) begin
                issue_cnt0 <= issue_cnt0 + 8'd1;
            end
            if (grant[1]) begin
                issue_cnt1 <= issue_cnt1 + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_arb.sv
// Self-checking bench for inst_issue_arb: per-cycle comparison against a
// transfer-level model plus directed scenarios with literal expectations.
module tb_inst_issue_arb;

    localparam logic [7:0] NOP     = 8'h00;
    localparam int         DRAIN_N = 2;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic       drain_req  = 1'b0;
    logic [7:0] req0_inst  = 8'h00;
    logic [7:0] req1_inst  = 8'h00;
    logic       req0_ready, req1_ready, drain_done, inst_src;
    logic [7:0] inst_out, issue_cnt0, issue_cnt1;

    int n_cmp  = 0;
    int n_miss = 0;

    // Directed table for the alternating-grant scenario.
    logic [7:0] alt_in0 [4] = '{8'h03, 8'h81, 8'h92, 8'hA3};
    logic [7:0] alt_in1 [4] = '{8'hC0, 8'hD1, 8'hE2, 8'hF3};
    logic [7:0] alt_out [4] = '{8'h03, 8'hD1, 8'h92, 8'hF3};
    logic       alt_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    inst_issue_arb #(
        .NOP_INST     (NOP),
        .DRAIN_CYCLES (DRAIN_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_inst  (req0_inst),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_inst  (req1_inst),
        .req1_ready (req1_ready),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .inst_out   (inst_out),
        .inst_src   (inst_src),
        .issue_cnt0 (issue_cnt0),
        .issue_cnt1 (issue_cnt1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {7'd0, act}, {7'd0, exp});
    endtask

    // Transfer-level model: priority side, drain cycles left, drained flag.
    logic       m_ptr     = 1'b0;
    int         m_left    = 0;
    logic       m_drained = 1'b0;
    logic [7:0] m_inst    = NOP;
    logic       m_src     = 1'b0;
    logic [7:0] m_cnt0    = 8'h00;
    logic [7:0] m_cnt1    = 8'h00;

    function automatic logic m_running();
        return rst && !m_drained && (m_left == 0);
    endfunction

    function automatic logic m_ready(input int side);
        logic mine, other;
        mine  = (side == 1) ? req1_valid : req0_valid;
        other = (side == 1) ? req0_valid : req1_valid;
        return m_running() && mine && (!other || (m_ptr == (side == 1)));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr     <= 1'b0;
            m_left    <= 0;
            m_drained <= 1'b0;
            m_inst    <= NOP;
            m_src     <= 1'b0;
            m_cnt0    <= 8'h00;
            m_cnt1    <= 8'h00;
        end else begin
            if (m_ready(0)) begin
                m_inst <= req0_inst;
                m_src  <= 1'b0;
                m_cnt0 <= m_cnt0 + 8'd1;
                m_ptr  <= 1'b1;
            end else if (m_ready(1)) begin
                m_inst <= req1_inst;
                m_src  <= 1'b1;
                m_cnt1 <= m_cnt1 + 8'd1;
                m_ptr  <= 1'b0;
            end else begin
                m_inst <= NOP;
                m_src  <= 1'b0;
            end
            if (m_running()) begin
                if (drain_req) m_left <= DRAIN_N;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_drained <= 1'b1;
            end else if (!drain_req) begin
                m_drained <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check_bit("ready0", req0_ready, m_ready(0));
        check_bit("ready1", req1_ready, m_ready(1));
        check_bit("ready_exclusive", req0_ready & req1_ready, 1'b0);
        check_bit("drain_done", drain_done, m_drained && drain_req);
        check("inst_out", inst_out, m_inst);
        check_bit("inst_src", inst_src, m_src);
        check("issue_cnt0", issue_cnt0, m_cnt0);
        check("issue_cnt1", issue_cnt1, m_cnt1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain_req  = 1'b0;
        req0_inst  = 8'h00;
        req1_inst  = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while rst is low, even with both requesters valid.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        check("rst_inst_out", inst_out, 8'h00);
        check_bit("rst_inst_src", inst_src, 1'b0);
        check("rst_cnt0", issue_cnt0, 8'h00);
        check("rst_cnt1", issue_cnt1, 8'h00);
        check_bit("rst_drain_done", drain_done, 1'b0);
        check_bit("rst_ready0", req0_ready, 1'b0);
        check_bit("rst_ready1", req1_ready, 1'b0);
        idle_inputs();
        tick();
        tick();

        // Single requester, back-to-back issue; first transfer right after reset.
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_inst  = 8'h41;
        #1;
        check_bit("solo_ready0", req0_ready, 1'b1);
        tick();
        check("solo_inst_a", inst_out, 8'h41);
        check_bit("solo_src_a", inst_src, 1'b0);
        check("solo_cnt_a", issue_cnt0, 8'd1);
        req0_inst = 8'h46;
        tick();
        check("solo_inst_b", inst_out, 8'h46);
        check("solo_cnt_b", issue_cnt0, 8'd2);
        req0_valid = 1'b0;
        tick();
        check("solo_nop", inst_out, NOP);

        // Both valid after reset: grants alternate 0,1,0,1.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_inst = alt_in0[k];
            req1_inst = alt_in1[k];
            tick();
            check("alt_inst", inst_out, alt_out[k]);
            check_bit("alt_src", inst_src, alt_src[k]);
        end
        idle_inputs();
        tick();
        check("alt_cnt0", issue_cnt0, 8'd2);
        check("alt_cnt1", issue_cnt1, 8'd2);

        // Drain with drain_req held: two drain cycles, then drain_done.
        drain_req = 1'b1;
        tick();
        check_bit("drain_c1_done", drain_done, 1'b0);
        check("drain_c1_nop", inst_out, NOP);
        tick();
        check_bit("drain_c2_done", drain_done, 1'b0);
        tick();
        check_bit("drained_done_a", drain_done, 1'b1);
        tick();
        check_bit("drained_done_b", drain_done, 1'b1);
        drain_req = 1'b0;
        #1;
        check_bit("drained_release", drain_done, 1'b0);
        tick();
        check_bit("run_done", drain_done, 1'b0);

        // Drain with both valid: same-cycle transfer completes, then frozen.
        drain_req  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_inst  = 8'h11;
        req1_inst  = 8'h22;
        #1;
        check_bit("drain_edge_ready0", req0_ready, 1'b1);
        tick();
        check("drain_edge_inst", inst_out, 8'h11);
        check("drain_edge_cnt0", issue_cnt0, 8'd3);
        for (int k = 0; k < 4; k++) begin
            check_bit("frozen_ready0", req0_ready, 1'b0);
            check_bit("frozen_ready1", req1_ready, 1'b0);
            tick();
        end
        check("frozen_cnt0", issue_cnt0, 8'd3);
        check("frozen_cnt1", issue_cnt1, 8'd2);
        drain_req = 1'b0;
        tick();
        check_bit("resume_ready1", req1_ready, 1'b1);
        check_bit("resume_ready0", req0_ready, 1'b0);
        tick();
        check("resume_inst", inst_out, 8'h22);
        check_bit("resume_src", inst_src, 1'b1);
        check("resume_cnt1", issue_cnt1, 8'd3);
        idle_inputs();
        tick();

        // One-cycle drain pulse: drain still runs to completion.
        drain_req = 1'b1;
        tick();
        drain_req  = 1'b0;
        req0_valid = 1'b1;
        req0_inst  = 8'h77;
        #1;
        check_bit("pulse_c1_ready0", req0_ready, 1'b0);
        tick();
        check_bit("pulse_c2_ready0", req0_ready, 1'b0);
        tick();
        check_bit("pulse_drained_ready0", req0_ready, 1'b0);
        check_bit("pulse_drained_done", drain_done, 1'b0);
        tick();
        check_bit("pulse_run_ready0", req0_ready, 1'b1);
        tick();
        check("pulse_inst", inst_out, 8'h77);
        check("pulse_cnt0", issue_cnt0, 8'd4);
        idle_inputs();
        tick();

        // 256 transfers from requester 1: counter wraps.
        do_reset();
        req1_valid = 1'b1;
        req1_inst  = 8'h3C;
        for (int k = 0; k < 255; k++) tick();
        check("wrap_cnt1_ff", issue_cnt1, 8'hFF);
        check("wrap_cnt0_a", issue_cnt0, 8'h00);
        tick();
        check("wrap_cnt1_00", issue_cnt1, 8'h00);
        check("wrap_cnt0_b", issue_cnt0, 8'h00);
        idle_inputs();
        tick();

        // Asynchronous reset between clock edges during DRAIN.
        drain_req  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_inst  = 8'h55;
        req1_inst  = 8'hAA;
        tick();
        check("pre_rst_inst", inst_out, 8'h55);
        check("pre_rst_cnt0", issue_cnt0, 8'd1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_inst_out", inst_out, 8'h00);
        check_bit("async_inst_src", inst_src, 1'b0);
        check("async_cnt0", issue_cnt0, 8'h00);
        check("async_cnt1", issue_cnt1, 8'h00);
        check_bit("async_ready0", req0_ready, 1'b0);
        check_bit("async_ready1", req1_ready, 1'b0);
        drain_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_bit("post_rst_ready0", req0_ready, 1'b1);
        check_bit("post_rst_ready1", req1_ready, 1'b0);
        tick();
        check("post_rst_inst", inst_out, 8'h55);
        check_bit("post_rst_src", inst_src, 1'b0);
        idle_inputs();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
